muldiv_ctrl: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipeline CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs a 32-step shift-add or restoring-divide loop. It also raises a stall to the pipeline control while a request or an MFHI/MFLO read collides with an in-flight operation. HI/LO outputs feed the EX-stage result path.

---
 rtl/muldiv_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// One shift-add or restoring-divide step per cycle over DATA_W cycles,
// followed by a single sign fix-up cycle that writes HI/LO.
module muldiv_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned OP_LENGTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [OP_LENGTH-1:0] op,
   input  logic [DATA_W-1:0]    opnd_a,
   input  logic [DATA_W-1:0]    opnd_b,
   input  logic                 hilo_rd,
   input  logic                 flush,
   output logic                 busy,
   output logic                 stall,
   output logic                 done,
   output logic [DATA_W-1:0]    hi,
   output logic [DATA_W-1:0]    lo
);

   localparam int unsigned CntW = $clog2(DATA_W);

   localparam logic [OP_LENGTH-1:0] OpMult  = OP_LENGTH'(0);
   localparam logic [OP_LENGTH-1:0] OpMultu = OP_LENGTH'(1);
   localparam logic [OP_LENGTH-1:0] OpDiv   = OP_LENGTH'(2);
   localparam logic [OP_LENGTH-1:0] OpDivu  = OP_LENGTH'(3);
   localparam logic [OP_LENGTH-1:0] OpMthi  = OP_LENGTH'(4);
   localparam logic [OP_LENGTH-1:0] OpMtlo  = OP_LENGTH'(5);

   typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

   state_e                state_q, state_d;
   logic                  is_div_q, is_div_d;
   logic                  neg_q, neg_d;     // product/quotient must be negated
   logic                  rneg_q, rneg_d;   // remainder must be negated
   logic                  divz_q, divz_d;   // divisor was zero
   logic [DATA_W-1:0]     araw_q, araw_d;   // original dividend for divide-by-zero
   logic [DATA_W-1:0]     opb_q, opb_d;     // multiplicand / divisor magnitude
   logic [2*DATA_W-1:0]   acc_q, acc_d;     // mult: {upper, multiplier}; div: {rem, quo}
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]     hi_q, hi_d;
   logic [DATA_W-1:0]     lo_q, lo_d;
   logic                  done_q, done_d;

   logic                  signed_op;
   logic [DATA_W-1:0]     mag_a, mag_b;
   logic [DATA_W:0]       mul_sum;
   logic [DATA_W:0]       div_shift;
   logic [DATA_W:0]       div_diff;

   // Operand magnitudes and single-step datapath helpers
   always_comb begin
      signed_op = (op == OpMult) || (op == OpDiv);
      mag_a     = (signed_op && opnd_a[DATA_W-1]) ? -opnd_a : opnd_a;
      mag_b     = (signed_op && opnd_b[DATA_W-1]) ? -opnd_b : opnd_b;
      mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_shift = acc_q[2*DATA_W-1:DATA_W-1];
      div_diff  = div_shift - {1'b0, opb_q};
   end

   // Next-state for the sequencer and HI/LO
   always_comb begin
      state_d  = state_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      divz_d   = divz_q;
      araw_d   = araw_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op == OpMult || op == OpMultu || op == OpDiv || op == OpDivu) begin
                  is_div_d = (op == OpDiv) || (op == OpDivu);
                  neg_d    = signed_op & (opnd_a[DATA_W-1] ^ opnd_b[DATA_W-1]);
                  rneg_d   = signed_op & opnd_a[DATA_W-1];
                  divz_d   = (opnd_b == '0);
                  araw_d   = opnd_a;
                  opb_d    = mag_b;
                  acc_d    = {{DATA_W{1'b0}}, mag_a};
                  cnt_d    = '0;
                  state_d  = StCalc;
               end else if (op == OpMthi) begin
                  hi_d = opnd_a;
               end else if (op == OpMtlo) begin
                  lo_d = opnd_a;
               end
            end
         end
         StCalc: begin
            if (is_div_q) begin
               // No borrow means the divisor fits: keep the difference, quotient bit 1
               if (!div_diff[DATA_W]) begin
                  acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
               end else begin
                  acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum, acc_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(DATA_W - 1)) begin
               state_d = StSign;
            end
         end
         StSign: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            end else if (divz_q) begin
               hi_d = araw_q;
               lo_d = '1;
            end else begin
               lo_d = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
               hi_d = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Squash wins over everything except reset, including MTHI/MTLO
      if (flush) begin
         state_d = StIdle;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         divz_q   <= 1'b0;
         araw_q   <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         divz_q   <= divz_d;
         araw_q   <= araw_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   // Outputs; stall is combinational on the live request inputs
   always_comb begin
      busy  = (state_q != StIdle);
      stall = busy & (start | hilo_rd);
      done  = done_q;
      hi    = hi_q;
      lo    = lo_q;
   end

endmodule
